seq_booth_multiplier: RTL and testbench
=======================================

Name: seq_booth_multiplier

Overview:
- Sequential radix-2 Booth multiplier: the parametrised successor of the team's 8-bit combinational carry-save signed multiplier.
- Generalised to WIDTH bits, with a runtime signed/unsigned mode, full 2*WIDTH product output and an overflow flag.
- Valid/ready handshakes on both input and output.
- Sits in the datapath as a low-area multiplier wherever a multi-cycle latency is acceptable.

Parameters:
- WIDTH, 8, operand width in bits; legal range 4..32.
- CNT_W, $clog2(WIDTH+2), iteration counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and mode are valid
- in_ready  output  1  block can accept operands
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned operands
- X  input  WIDTH  multiplicand
- Y  input  WIDTH  multiplier
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  consumer accepts result
- Z  output  WIDTH  low WIDTH bits of product (saturated if OVF_SATURATE_EN)
- P  output  2*WIDTH  full exact product
- overflow  output  1  product not representable in WIDTH bits under the selected mode

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE, in_ready=1, out_valid=0, Z=0, P=0, overflow=0, all internal registers cleared.
- Reset asserted mid-operation aborts the operation; no result is produced.

Input handshake:
- Accept on the rising edge where in_valid && in_ready.
- in_ready=1 only in IDLE.
- On accept, latch X, Y and signed_mode.
- Extend both operands to WIDTH+1 bits: sign-extend if signed_mode=1, zero-extend if 0.
- Clear the accumulator and the Booth bit Y[-1]; set counter=0; go to BUSY.
- X, Y and signed_mode changing after accept have no effect.

BUSY:
- One Booth step per cycle, exactly WIDTH+1 steps.
- Per step, examine {Y[0], Y[-1]}: 01 adds the extended multiplicand to the upper accumulator, 10 subtracts it, 00/11 leave it unchanged.
- Then arithmetic-shift-right the {accumulator, Y, Y[-1]} register by 1.
- Accumulator width WIDTH+2 bits so the add/subtract never loses its sign.
- After step WIDTH+1, go to DONE.

Latency:
- out_valid rises exactly WIDTH+2 rising edges after the accepting edge (10 for WIDTH=8).
- Occupancy per operation is WIDTH+3 cycles minimum.

DONE:
- out_valid=1; Z, P and overflow are stable.
- On an edge with out_ready=1: out_valid drops, go to IDLE, in_ready=1 next cycle.
- out_ready=1 arriving early is ignored until DONE.
- Z, P and overflow keep their last values in IDLE.

Arithmetic:
- P = exact product, low 2*WIDTH bits of the extended Booth result.
- Signed P is a two's-complement value; unsigned P is an unsigned value.

Overflow:
- Signed: set unless P[2*WIDTH-1:WIDTH-1] are all equal.
- Unsigned: set when P[2*WIDTH-1:WIDTH] != 0.

Boundary cases (exact P required):
- Zero operands.
- X = most-negative (signed) or all-ones (unsigned).
- Both operands most-negative.

Optional Feature:
- Macro OVF_SATURATE_EN.
- Defined: when overflow=1, Z saturates instead of truncating.
  - Signed, P[2*WIDTH-1]=0: Z = 2^(WIDTH-1)-1.
  - Signed, P[2*WIDTH-1]=1: Z = -2^(WIDTH-1).
  - Unsigned: Z = all ones.
  - When overflow=0, Z = P[WIDTH-1:0].
- Undefined: Z = P[WIDTH-1:0] always.
- P and overflow are identical in both builds.

Test Plan:
- WIDTH=8, signed, X=12, Y=-5 -> P=0xFFC4, Z=0xC4, overflow=0; out_valid exactly 10 edges after accept.
- Signed, X=127, Y=-128 -> P=0xC080, overflow=1; Z=0x80, or Z=0x80 (-128) with OVF_SATURATE_EN.
- Signed, X=-128, Y=-1 -> P=0x0080, overflow=1; Z=0x80, or 0x7F with OVF_SATURATE_EN.
- Unsigned, X=255, Y=255 -> P=0xFE01, overflow=1; Z=0x01, or 0xFF with OVF_SATURATE_EN.
- Handshake: hold out_ready=0 for 5 cycles in DONE -> out_valid, Z and P stable, in_ready=0; raise out_ready -> in_ready=1 next cycle. Drive in_valid=1 during BUSY -> not accepted.
- Assert reset 3 cycles into BUSY -> all outputs zero immediately (asynchronous), in_ready=1 after release. A following signed X=-128, Y=-128 -> P=0x4000, overflow=1.

Source files
------------

// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier
//   Sequential radix-2 Booth multiplier with valid/ready handshakes.
//   Operands are extended to WIDTH+1 bits: sign-extended in signed mode, zero-extended
//   in unsigned mode. The block then runs WIDTH+1 Booth steps, one per cycle, and
//   registers the result on the following cycle.
//
//   Optional build macro: OVF_SATURATE_EN. When it is defined, Z saturates on overflow.
//   When it is undefined, Z is the truncated low half of P.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     operands and mode are valid
//   in_ready     block can accept operands (IDLE only)
//   signed_mode  1 = two's-complement operands, 0 = unsigned operands
//   X, Y         multiplicand, multiplier (WIDTH bits)
//   out_valid    result valid, held until accepted
//   out_ready    consumer accepts result
//   Z            low WIDTH bits of product (saturated with OVF_SATURATE_EN)
//   P            full exact 2*WIDTH-bit product
//   overflow     product not representable in WIDTH bits under the selected mode
//
// States
//   S_IDLE | waiting for operands, in_ready=1
//   S_BUSY | Booth steps (cnt 0..WIDTH), then one cycle to register the result
//   S_DONE | out_valid=1, waiting for out_ready

module seq_booth_multiplier #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     Z,
    output logic [2*WIDTH-1:0]   P,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [WIDTH:0]        r_mcand;
    logic [WIDTH:0]        r_mplier;
    logic [WIDTH+1:0]      r_acc;
    logic                  r_ybit;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_signed;
    logic [WIDTH-1:0]      r_z;
    logic [2*WIDTH-1:0]    r_p;
    logic                  r_ovf;

    logic                  w_accept;
    logic                  w_finish;
    logic [WIDTH:0]        w_x_ext;
    logic [WIDTH:0]        w_y_ext;
    logic [WIDTH+1:0]      w_mcand_x;
    logic [WIDTH+1:0]      w_acc_sum;
    logic [2*WIDTH-1:0]    w_prod;
    logic [WIDTH:0]        w_prod_hi;
    logic                  w_ovf;
    logic [WIDTH-1:0]      w_z;
    logic                  w_unused;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    // The count reaches WIDTH+1 only after the last Booth step, so that cycle
    // only registers the result.
    assign w_finish  = (r_cnt == CNT_W'(WIDTH + 1));

    assign w_x_ext   = signed_mode ? {X[WIDTH-1], X} : {1'b0, X};
    assign w_y_ext   = signed_mode ? {Y[WIDTH-1], Y} : {1'b0, Y};
    assign w_mcand_x = {r_mcand[WIDTH], r_mcand};

    always_comb begin
        w_acc_sum = r_acc;
        case ({r_mplier[0], r_ybit})
            2'b01:   w_acc_sum = r_acc + w_mcand_x;
            2'b10:   w_acc_sum = r_acc - w_mcand_x;
            default: w_acc_sum = r_acc;
        endcase
    end

    // After WIDTH+1 shifts, {acc, mplier} holds the sign-extended product. The low
    // 2*WIDTH bits are exact for both modes.
    assign w_prod    = {r_acc[WIDTH-2:0], r_mplier};
    assign w_prod_hi = w_prod[2*WIDTH-1:WIDTH-1];
    assign w_ovf     = r_signed ? !((&w_prod_hi) || !(|w_prod_hi))
                                : (|w_prod[2*WIDTH-1:WIDTH]);

`ifdef OVF_SATURATE_EN
    always_comb begin
        w_z = w_prod[WIDTH-1:0];
        if (w_ovf) begin
            if (r_signed) begin
                w_z = w_prod[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                w_z = '1;
            end
        end
    end
`else
    assign w_z = w_prod[WIDTH-1:0];
`endif

    // The guard bits of the accumulator are never part of P.
    assign w_unused = &{1'b0, r_acc[WIDTH+1:WIDTH-1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_finish) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_ybit   <= 1'b0;
            r_cnt    <= '0;
            r_signed <= 1'b0;
            r_z      <= '0;
            r_p      <= '0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= w_x_ext;
            r_mplier <= w_y_ext;
            r_signed <= signed_mode;
            r_acc    <= '0;
            r_ybit   <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == S_BUSY) begin
            if (!w_finish) begin
                // Add or subtract the multiplicand, then shift {acc, mplier, ybit}
                // right arithmetically by one bit.
                r_acc    <= {w_acc_sum[WIDTH+1], w_acc_sum[WIDTH+1:1]};
                r_mplier <= {w_acc_sum[0], r_mplier[WIDTH:1]};
                r_ybit   <= r_mplier[0];
                r_cnt    <= r_cnt + CNT_W'(1);
            end else begin
                r_p      <= w_prod;
                r_z      <= w_z;
                r_ovf    <= w_ovf;
            end
        end
    end

    assign Z        = r_z;
    assign P        = r_p;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
module tb_seq_booth_multiplier;

    localparam int W = 8;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic           signed_mode;
    logic [W-1:0]   X;
    logic [W-1:0]   Y;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   Z;
    logic [2*W-1:0] P;
    logic           overflow;

    int n_vec = 0;
    int n_err = 0;

    seq_booth_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .signed_mode (signed_mode),
        .X           (X),
        .Y           (Y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Z           (Z),
        .P           (P),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer multiplication of the operands as interpreted by the mode.
    task automatic model(input logic sgn, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [2*W-1:0] ep, output logic [W-1:0] ez, output logic eo);
        int a;
        int b;
        int prod;
        a    = sgn ? int'($signed(x)) : int'(x);
        b    = sgn ? int'($signed(y)) : int'(y);
        prod = a * b;
        ep   = prod[2*W-1:0];
        if (sgn) eo = (prod > 127) || (prod < -128);
        else     eo = (prod > 255);
        ez = prod[W-1:0];
`ifdef OVF_SATURATE_EN
        if (eo) begin
            if (sgn) ez = (prod < 0) ? 8'h80 : 8'h7F;
            else     ez = 8'hFF;
        end
`endif
    endtask

    task automatic run_op(input logic sgn, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int hold, input logic early, input logic busy_poke);
        logic [2*W-1:0] ep;
        logic [W-1:0]   ez;
        logic           eo;
        int             lat;
        model(sgn, x, y, ep, ez, eo);
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        signed_mode = sgn;
        X           = x;
        Y           = y;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Operand changes after the accepting edge must not matter.
        in_valid    = busy_poke;
        X           = W'($urandom);
        Y           = W'($urandom);
        signed_mode = 1'($urandom);
        out_ready   = early;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        chk("latency", 64'(lat), 64'd10);
        chk("P", 64'(P), 64'(ep));
        chk("Z", 64'(Z), 64'(ez));
        chk("overflow", 64'(overflow), 64'(eo));
        chk("in_ready_done", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                chk("hold_out_valid", 64'(out_valid), 64'd1);
                chk("hold_P", 64'(P), 64'(ep));
                chk("hold_Z", 64'(Z), 64'(ez));
                chk("hold_in_ready", 64'(in_ready), 64'd0);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("idle_P_kept", 64'(P), 64'(ep));
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        signed_mode = 1'b0;
        X           = '0;
        Y           = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_P", 64'(P), 64'd0);
        chk("rst_Z", 64'(Z), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(1'b1, 8'd12,  8'hFB, 0, 1'b0, 1'b0);
        run_op(1'b1, 8'd127, 8'h80, 0, 1'b0, 1'b0);
        run_op(1'b1, 8'h80,  8'hFF, 0, 1'b0, 1'b0);
        run_op(1'b0, 8'hFF,  8'hFF, 5, 1'b0, 1'b1);
        run_op(1'b0, 8'h00,  8'h5A, 0, 1'b1, 1'b0);
        run_op(1'b1, 8'h00,  8'h00, 1, 1'b0, 1'b0);
        run_op(1'b0, 8'hFF,  8'h01, 0, 1'b0, 1'b0);
        run_op(1'b1, 8'h80,  8'h01, 0, 1'b0, 1'b0);

        // Reset three cycles into BUSY aborts the operation.
        @(negedge clk);
        signed_mode = 1'b1;
        X           = 8'h33;
        Y           = 8'h44;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_P", 64'(P), 64'd0);
        chk("abort_Z", 64'(Z), 64'd0);
        chk("abort_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        repeat (15) @(posedge clk);
        #1;
        chk("abort_no_result", 64'(out_valid), 64'd0);
        run_op(1'b1, 8'h80, 8'h80, 0, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            run_op(1'($urandom), W'($urandom), W'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                   1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
